// File: rtl/nf_uart_pkg.sv
// Shared types for the nanoFOX UART receiver: FSM states, frame-length
// encodings and the RX FIFO entry layout.
package nf_uart_pkg;

   typedef enum logic [2:0] {
      IDLE_s,
      START_s,
      DATA_s,
      PARITY_s,
      STOP_s
   } rx_state_t;

   localparam logic [1:0] DLEN_5 = 2'd0;
   localparam logic [1:0] DLEN_6 = 2'd1;
   localparam logic [1:0] DLEN_7 = 2'd2;
   localparam logic [1:0] DLEN_8 = 2'd3;

   typedef struct packed {
      logic       perr;
      logic       ferr;
      logic [7:0] data;
   } rx_entry_t;

   // Bit index of the last data bit for a given data_len code.
   function automatic logic [2:0] last_bit_idx(input logic [1:0] dlen);
      return {1'b0, dlen} + 3'd4;
   endfunction

endpackage

// File: rtl/nf_uart_rx_buf.sv
// Synchronous RX FIFO of rx_entry_t with push/pop/flush and occupancy level.
module nf_uart_rx_buf
   import nf_uart_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  rx_entry_t                  wdata,
   output rx_entry_t                  rdata,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

   rx_entry_t       mem_q [DEPTH];
   rx_entry_t       mem_d [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     level_q, level_d;
   logic            do_push, do_pop;

   assign empty = (level_q == '0);
   assign full  = (level_q == LVL_FULL);
   assign level = level_q;
   assign rdata = mem_q[rd_ptr_q];

   // A pop frees the head slot in the same cycle, so push is allowed when full.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         if (do_push && !do_pop) begin
            level_d = level_q + (AW+1)'(1);
         end else if (do_pop && !do_push) begin
            level_d = level_q - (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

endmodule

// File: rtl/nf_uart_rx_fifo.sv
// nanoFOX UART receiver: synchroniser, start/data/parity/stop FSM with
// per-character parity/framing flags, feeding an RX FIFO.
module nf_uart_rx_fifo
   import nf_uart_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int COMP_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          rec_en,
   input  logic [COMP_W-1:0]             comp,
   input  logic [1:0]                    data_len,
   input  logic                          par_en,
   input  logic                          par_odd,
   input  logic                          stop2,
   output logic [7:0]                    rx_data,
   output logic                          rx_perr,
   output logic                          rx_ferr,
   output logic                          rx_valid,
   input  logic                          rx_pop,
   output logic [$clog2(FIFO_DEPTH):0]   rx_level,
   output logic                          overrun,
   input  logic                          err_clr,
   input  logic                          uart_rx
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   rxs, rxs_prev_q, rxs_prev_d, rxs_fall;
   rx_state_t              state_q, state_d;
   logic [COMP_W-1:0]      cnt_q, cnt_d, cnt_bit;
   logic [2:0]             bit_idx_q, bit_idx_d;
   logic [7:0]             data_q, data_d;
   logic                   perr_q, perr_d;
   logic                   ferr_q, ferr_d;
   logic                   stop_idx_q, stop_idx_d;
   logic                   overrun_q, overrun_d;
   logic                   sample, stop_ferr;
   logic                   push, drop;
   rx_entry_t              push_entry, head;
   logic                   buf_full, buf_empty;

   assign sync_d     = {sync_q[SYNC_STAGES-2:0], uart_rx};
   assign rxs        = sync_q[SYNC_STAGES-1];
   assign rxs_prev_d = rxs;
   assign rxs_fall   = rxs_prev_q & ~rxs;
   assign sample     = (cnt_q == comp);
   assign cnt_bit    = sample ? '0 : cnt_q + COMP_W'(1);
   assign stop_ferr  = ferr_q | ~rxs;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_idx_d  = bit_idx_q;
      data_d     = data_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      stop_idx_d = stop_idx_q;
      push       = 1'b0;
      push_entry = '{perr: perr_q, ferr: stop_ferr, data: data_q};
      if (!rec_en) begin
         state_d    = IDLE_s;
         cnt_d      = '0;
         bit_idx_d  = '0;
         stop_idx_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE_s: begin
               cnt_d     = '0;
               bit_idx_d = '0;
               if (rxs_fall) begin
                  state_d    = START_s;
                  data_d     = '0;
                  perr_d     = 1'b0;
                  ferr_d     = 1'b0;
                  stop_idx_d = 1'b0;
               end
            end
            START_s: begin
               // Half-bit check; restarting cnt here puts later samples mid-bit.
               if (cnt_q == (comp >> 1)) begin
                  cnt_d   = '0;
                  state_d = rxs ? IDLE_s : DATA_s;
               end else begin
                  cnt_d = cnt_q + COMP_W'(1);
               end
            end
            DATA_s: begin
               cnt_d = cnt_bit;
               if (sample) begin
                  data_d[bit_idx_q] = rxs;
                  if (bit_idx_q == last_bit_idx(data_len)) begin
                     bit_idx_d = '0;
                     state_d   = par_en ? PARITY_s : STOP_s;
                  end else begin
                     bit_idx_d = bit_idx_q + 3'd1;
                  end
               end
            end
            PARITY_s: begin
               cnt_d = cnt_bit;
               if (sample) begin
                  perr_d  = ((^data_q) ^ rxs) != par_odd;
                  state_d = STOP_s;
               end
            end
            STOP_s: begin
               cnt_d = cnt_bit;
               if (sample) begin
                  if (stop2 && !stop_idx_q) begin
                     stop_idx_d = 1'b1;
                     ferr_d     = stop_ferr;
                  end else begin
                     push    = 1'b1;
                     state_d = IDLE_s;
                     cnt_d   = '0;
                  end
               end
            end
            default: state_d = IDLE_s;
         endcase
      end
   end

   assign drop = push & buf_full & ~(rx_pop & ~buf_empty);

   always_comb begin
      overrun_d = overrun_q;
      if (err_clr) overrun_d = 1'b0;
      if (drop)    overrun_d = 1'b1;
      if (!rec_en) overrun_d = 1'b0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync_q     <= '1;
         rxs_prev_q <= 1'b1;
         state_q    <= IDLE_s;
         cnt_q      <= '0;
         bit_idx_q  <= '0;
         data_q     <= '0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         stop_idx_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         rxs_prev_q <= rxs_prev_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         data_q     <= data_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         stop_idx_q <= stop_idx_d;
         overrun_q  <= overrun_d;
      end
   end

   nf_uart_rx_buf #(
      .DEPTH (FIFO_DEPTH)
   ) u_buf (
      .clk    (clk),
      .resetn (resetn),
      .flush  (~rec_en),
      .push   (push),
      .pop    (rx_pop),
      .wdata  (push_entry),
      .rdata  (head),
      .level  (rx_level),
      .full   (buf_full),
      .empty  (buf_empty)
   );

   assign rx_data  = head.data;
   assign rx_perr  = head.perr;
   assign rx_ferr  = head.ferr;
   assign rx_valid = ~buf_empty;
   assign overrun  = overrun_q;

endmodule

// File: tb/tb_nf_uart_rx_fifo.sv
// Directed self-checking bench for nf_uart_rx_fifo at comp=9 (10 clocks/bit).
module tb_nf_uart_rx_fifo;

   logic        clk = 1'b0;
   logic        resetn, rec_en;
   logic [15:0] comp;
   logic [1:0]  data_len;
   logic        par_en, par_odd, stop2;
   logic [7:0]  rx_data;
   logic        rx_perr, rx_ferr, rx_valid, rx_pop;
   logic [3:0]  rx_level;
   logic        overrun, err_clr, uart_rx;

   int checks = 0;
   int errors = 0;

   nf_uart_rx_fifo #(
      .FIFO_DEPTH  (8),
      .COMP_W      (16),
      .SYNC_STAGES (2)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .rec_en   (rec_en),
      .comp     (comp),
      .data_len (data_len),
      .par_en   (par_en),
      .par_odd  (par_odd),
      .stop2    (stop2),
      .rx_data  (rx_data),
      .rx_perr  (rx_perr),
      .rx_ferr  (rx_ferr),
      .rx_valid (rx_valid),
      .rx_pop   (rx_pop),
      .rx_level (rx_level),
      .overrun  (overrun),
      .err_clr  (err_clr),
      .uart_rx  (uart_rx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drives one bit for one bit time; called on a falling clock edge.
   task automatic bit_out(input logic v);
      uart_rx = v;
      repeat (10) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] d, input int nb, input logic pen,
                       input logic podd, input logic flip, input logic s2,
                       input logic stopv);
      logic p;
      p = podd ^ flip;
      bit_out(1'b0);
      for (int i = 0; i < nb; i++) begin
         bit_out(d[i]);
         p ^= d[i];
      end
      if (pen) bit_out(p);
      bit_out(stopv);
      if (s2) bit_out(stopv);
   endtask

   task automatic pop1;
      rx_pop = 1'b1;
      @(negedge clk);
      rx_pop = 1'b0;
   endtask

   initial begin
      logic [7:0] d;
      resetn = 1'b0; rec_en = 1'b0; comp = 16'd9; data_len = 2'd3;
      par_en = 1'b0; par_odd = 1'b0; stop2 = 1'b0;
      rx_pop = 1'b0; err_clr = 1'b0; uart_rx = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_data", rx_data, 8'h00);
      chk("reset_flags", {rx_perr, rx_ferr, rx_valid, overrun}, 4'b0000);
      chk("reset_level", rx_level, 4'd0);
      resetn = 1'b1; rec_en = 1'b1;
      repeat (5) @(negedge clk);

      // 8N1 0xA5 with exact latency check around the stop mid-sample.
      d = 8'hA5;
      bit_out(1'b0);
      for (int i = 0; i < 8; i++) bit_out(d[i]);
      uart_rx = 1'b1;
      repeat (7) @(negedge clk);
      chk("t1_valid_before", rx_valid, 1'b0);
      @(negedge clk);
      chk("t1_valid_after", rx_valid, 1'b1);
      repeat (2) @(negedge clk);
      chk("t1_data", rx_data, 8'hA5);
      chk("t1_flags", {rx_perr, rx_ferr}, 2'b00);
      chk("t1_level", rx_level, 4'd1);
      pop1();
      chk("t1_pop_valid", rx_valid, 1'b0);
      chk("t1_pop_level", rx_level, 4'd0);

      // 7E2: correct parity, then flipped parity.
      data_len = 2'd2; par_en = 1'b1; par_odd = 1'b0; stop2 = 1'b1;
      send(8'h35, 7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      send(8'h35, 7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("t2_level", rx_level, 4'd2);
      chk("t2_data0", rx_data, 8'h35);
      chk("t2_flags0", {rx_perr, rx_ferr}, 2'b00);
      pop1();
      chk("t2_data1", rx_data, 8'h35);
      chk("t2_flags1", {rx_perr, rx_ferr}, 2'b10);
      pop1();
      data_len = 2'd3; par_en = 1'b0; stop2 = 1'b0;
      repeat (5) @(negedge clk);

      // Framing error, line held low, then a clean character.
      send(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (30) @(negedge clk);
      uart_rx = 1'b1;
      repeat (20) @(negedge clk);
      send(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("t3_level", rx_level, 4'd2);
      chk("t3_data0", rx_data, 8'h3C);
      chk("t3_flags0", {rx_perr, rx_ferr}, 2'b01);
      pop1();
      chk("t3_data1", rx_data, 8'h11);
      chk("t3_flags1", {rx_perr, rx_ferr}, 2'b00);
      pop1();

      // 4-clock glitch must be rejected as a false start.
      uart_rx = 1'b0;
      repeat (4) @(negedge clk);
      uart_rx = 1'b1;
      repeat (30) @(negedge clk);
      chk("t4_level", rx_level, 4'd0);
      chk("t4_valid", rx_valid, 1'b0);

      // Overflow: nine characters into eight entries.
      for (int i = 0; i < 9; i++) send(8'(i), 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("t5_level", rx_level, 4'd8);
      chk("t5_overrun", overrun, 1'b1);
      chk("t5_head", rx_data, 8'h00);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("t5_pop%0d", i), rx_data, 8'(i));
         pop1();
      end
      chk("t5_empty_level", rx_level, 4'd0);
      chk("t5_overrun_sticky", overrun, 1'b1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("t5_overrun_clr", overrun, 1'b0);

      // rec_en drop mid-frame flushes queue and discards the partial char.
      send(8'h01, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      send(8'h02, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("t6_level_pre", rx_level, 4'd2);
      bit_out(1'b0);
      bit_out(1'b1);
      bit_out(1'b0);
      rec_en = 1'b0;
      uart_rx = 1'b1;
      repeat (2) @(negedge clk);
      chk("t6_level", rx_level, 4'd0);
      chk("t6_valid", rx_valid, 1'b0);
      chk("t6_overrun", overrun, 1'b0);
      repeat (20) @(negedge clk);
      rec_en = 1'b1;
      repeat (5) @(negedge clk);
      send(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("t6_level_post", rx_level, 4'd1);
      chk("t6_data", rx_data, 8'h5A);
      pop1();

      // Enabling while the line is already low must not start a frame.
      rec_en = 1'b0;
      uart_rx = 1'b0;
      repeat (5) @(negedge clk);
      rec_en = 1'b1;
      repeat (120) @(negedge clk);
      chk("t7_no_frame", rx_level, 4'd0);
      uart_rx = 1'b1;
      repeat (20) @(negedge clk);
      send(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("t7_level", rx_level, 4'd1);
      chk("t7_data", rx_data, 8'hC3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/nf_uart_rx_fifo.md
Name: nf_uart_rx_fifo

Overview:
Parametrised next-generation UART receiver for the nanoFOX periphery.
- Runtime-selectable frame format: 5–8 data bits, optional even/odd parity, 1 or 2 stop bits.
- Synchronises the asynchronous rx line, validates the start bit mid-bit, and flags framing and parity errors per character.
- Buffers received characters in an RX FIFO read by the UART controller, replacing the single-register valid/clear scheme.

Parameters:
FIFO_DEPTH, 8, number of RX FIFO entries (power of two, >=2)
COMP_W, 16, width of baud compare value
SYNC_STAGES, 2, flip-flops in the uart_rx synchroniser (>=2)

Ports:
clk  input  1  clock
resetn  input  1  reset, asynchronous, active-low
rec_en  input  1  receiver enable; low = FSM idle, FIFO flushed
comp  input  COMP_W  clocks per bit minus 1 (valid range >=3)
data_len  input  2  data bits: 0=5, 1=6, 2=7, 3=8
par_en  input  1  parity bit present
par_odd  input  1  1=odd parity, 0=even
stop2  input  1  1=two stop bits
rx_data  output  8  FIFO head data, LSB-aligned, unused MSBs zero
rx_perr  output  1  parity error flag of head entry
rx_ferr  output  1  framing error flag of head entry
rx_valid  output  1  FIFO not empty
rx_pop  input  1  pop head entry (ignored when empty)
rx_level  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy
overrun  output  1  sticky: a character was dropped because the FIFO was full
err_clr  input  1  clears overrun
uart_rx  input  1  UART rx wire (asynchronous)

Behaviour:
Reset values:
- All outputs 0. FIFO empty. FSM in IDLE.
- Synchroniser flops reset to 1 (line idle).
Synchronised line:
- rxs = last synchroniser stage.
- Start detection uses a falling edge of rxs (previous 1, current 0), not level.
FSM states: IDLE, START, DATA, PARITY, STOP.
Bit counter:
- cnt counts 0..comp, wraps to 0.
- A sample occurs when cnt==comp, i.e. mid-bit once phase-aligned.
IDLE:
- cnt=0, bit_idx=0.
- On rxs falling edge -> START.
START:
- At cnt==comp>>1, sample rxs and reset cnt to 0 (aligns to mid-bit).
- rxs=1: false start -> IDLE, nothing pushed.
- rxs=0 -> DATA.
DATA:
- Each sample shifts rxs into bit position bit_idx (LSB first).
- After data_len+5 samples: -> PARITY if par_en, else -> STOP.
PARITY:
- Sample once.
- perr = XOR(data bits, sampled bit) != par_odd.
STOP:
- Sample 1 stop bit, or 2 if stop2. ferr = any sampled stop bit == 0.
- At the final stop sample, push {perr, ferr, data} and go to IDLE in the same cycle.
- After a framing error, the next start requires rxs to return high first; edge detection enforces this, no break-flood.
FIFO:
- Push is visible on rx_valid/rx_data the cycle after the push.
- rx_pop is honoured only when rx_valid=1.
- Pop and push in the same cycle: level unchanged, allowed even when full.
- Push when full without pop: character dropped, overrun set.
- overrun: sticky until err_clr. err_clr and a new overrun in the same cycle -> overrun stays 1.
- Pointers wrap modulo FIFO_DEPTH.
rec_en:
- rec_en=0 (including mid-frame): FSM -> IDLE, cnt=0, partial character discarded, FIFO flushed, overrun cleared.
- Rising rec_en while the line is low does not start a frame; a falling edge is required.
Config changes:
- data_len, par_en, par_odd, stop2 and comp are sampled live.
- Changing them mid-frame is undefined; software changes them only while rec_en=0.
Latency: final stop mid-sample to rx_valid high = 1 clock (plus SYNC_STAGES clocks from the pin).

Decomposition:
- Package nf_uart_pkg holds:
  - FSM state enum (IDLE_s, START_s, DATA_s, PARITY_s, STOP_s);
  - data_len encoding constants;
  - FIFO entry struct {perr, ferr, data[7:0]}.
- One sub-module: nf_uart_rx_buf, a synchronous FIFO of FIFO_DEPTH entries of the 10-bit struct, with push/pop/flush, level, full and empty.

Test Plan:
1. comp=9, 8N1, send 0xA5 -> rx_valid rises 1 clk after stop mid-sample; rx_data=0xA5, perr=ferr=0; rx_pop -> rx_valid=0, rx_level=0.
2. comp=9, 7E2, send 0x35 with correct parity, then 0x35 with parity bit flipped -> entries 0x35/perr=0 then 0x35/perr=1; rx_data bit7=0.
3. comp=9, 8N1, send 0x3C with stop bit driven 0 -> entry 0x3C, ferr=1; line held low 30 clks then high, send 0x11 -> second entry 0x11, ferr=0.
4. 4-clock low glitch on idle line with comp=9 -> START sees rxs=1 at cnt=4, returns to IDLE; rx_level stays 0.
5. FIFO_DEPTH=8, send 9 characters 0x00..0x08 without popping -> rx_level=8, overrun=1, head 0x00, 0x08 lost. Pop all -> 0x00..0x07 in order. err_clr -> overrun=0.
6. Deassert rec_en during DATA of 0x55 with 2 entries queued -> rx_level=0, rx_valid=0, overrun=0. Re-enable, send 0x5A -> only 0x5A received.
